// File: rtl/ahbl_sram_xwait.sv
`default_nettype none
// ============================================================================
// ahbl_sram_xwait : AHB-Lite SRAM slave, read wait states, write-to-read fwd
// Revision 1.0
// ============================================================================
module ahbl_sram_xwait #(
  parameter int MEM_DEPTH = 16384,
  parameter int RD_WAIT   = 0,
  parameter int FWD_EN    = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADYIN,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  localparam int         AW         = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] WAIT_INIT  = (RD_WAIT > 0) ? 2'(RD_WAIT - 1) : 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RWAIT = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } state_t;

  state_t        state_q,     state_d;
  logic [1:0]    wcnt_q,      wcnt_d;
  logic          hreadyout_q, hreadyout_d;
  logic [1:0]    hresp_q,     hresp_d;
  logic          rd_valid_q,  rd_valid_d;
  logic          wr_pend_q,   wr_pend_d;
  logic [AW-1:0] wr_idx_q,    wr_idx_d;
  logic [3:0]    wr_be_q,     wr_be_d;
  logic          fwd_q,       fwd_d;
  logic [3:0]    fwd_be_q,    fwd_be_d;
  logic [31:0]   fwd_data_q,  fwd_data_d;
  logic [31:0]   rd_word_q;
  logic [31:0]   mem [MEM_DEPTH];

  logic          accept;
  logic          addr_err;
  logic          rd_launch;
  logic          mem_we;
  logic [AW-1:0] addr_idx;
  logic [3:0]    addr_be;
  logic [31:0]   rd_merged;
  logic          unused_bits;

  assign unused_bits = ^{HTRANS[0], HBURST};

  // New address phases are only taken while no wait or error response is active.
  assign accept   = HSEL & HREADYIN & HTRANS[1] & (state_q == ST_IDLE);
  assign addr_idx = HADDR[AW+1:2];
  assign addr_err = (|HADDR[31:AW+2]) | (HSIZE > 3'd2) |
                    ((HSIZE == 3'd1) & HADDR[0]) |
                    ((HSIZE == 3'd2) & (|HADDR[1:0]));
  assign mem_we   = wr_pend_q & ~HRESET;

  always_comb begin
    addr_be = 4'b1111;
    case (HSIZE)
      3'd0:    addr_be = 4'b0001 << HADDR[1:0];
      3'd1:    addr_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: addr_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    hreadyout_d = 1'b1;
    hresp_d     = RESP_OKAY;
    rd_valid_d  = 1'b0;
    wr_pend_d   = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_be_d     = wr_be_q;
    fwd_d       = fwd_q;
    fwd_be_d    = fwd_be_q;
    fwd_data_d  = fwd_data_q;
    rd_launch   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (addr_err) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = RESP_ERROR;
          end else if (HWRITE) begin
            wr_pend_d = 1'b1;
            wr_idx_d  = addr_idx;
            wr_be_d   = addr_be;
          end else begin
            rd_launch  = 1'b1;
            // A write finishing this cycle to the same word lands after the array read.
            fwd_d      = (FWD_EN != 0) && wr_pend_q && (wr_idx_q == addr_idx);
            fwd_be_d   = wr_be_q;
            fwd_data_d = HWDATA;
            if (RD_WAIT == 0) begin
              rd_valid_d = 1'b1;
            end else begin
              state_d     = ST_RWAIT;
              wcnt_d      = WAIT_INIT;
              hreadyout_d = 1'b0;
            end
          end
        end
      end
      ST_RWAIT: begin
        if (wcnt_q == 2'd0) begin
          state_d    = ST_IDLE;
          rd_valid_d = 1'b1;
        end else begin
          wcnt_d      = wcnt_q - 2'd1;
          hreadyout_d = 1'b0;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        hresp_d = RESP_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= 2'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
      rd_valid_q  <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_idx_q    <= '0;
      wr_be_q     <= 4'b0000;
      fwd_q       <= 1'b0;
      fwd_be_q    <= 4'b0000;
      fwd_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      rd_valid_q  <= rd_valid_d;
      wr_pend_q   <= wr_pend_d;
      wr_idx_q    <= wr_idx_d;
      wr_be_q     <= wr_be_d;
      fwd_q       <= fwd_d;
      fwd_be_q    <= fwd_be_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_q[b]) begin
          mem[wr_idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
    if (rd_launch) begin
      rd_word_q <= mem[addr_idx];
    end
  end

  always_comb begin
    rd_merged = rd_word_q;
    if (fwd_q) begin
      for (int b = 0; b < 4; b++) begin
        if (fwd_be_q[b]) begin
          rd_merged[8*b +: 8] = fwd_data_q[8*b +: 8];
        end
      end
    end
  end

  assign HRDATA    = rd_valid_q ? rd_merged : 32'd0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule
`default_nettype wire

// File: doc/ahbl_sram_xwait.md
AHBL_SRAM_XWAIT -- requirements
Module: ahbl_sram_xwait

Interface
REQ-001 Parameter MEM_DEPTH, default 16384, SHALL give the 32-bit word count; legal values are powers of two from 256 to 65536.
REQ-002 Parameter RD_WAIT, default 0, SHALL give the number of read wait states inserted per read; legal values are 0 to 3.
REQ-003 Parameter FWD_EN, default 1, SHALL enable write-to-read data forwarding when set to 1.
REQ-004 HCLK  in  1  the only clock; all logic SHALL be clocked on its rising edge.
REQ-005 HRESET  in  1  reset, synchronous and active-high.
REQ-006 HSEL  in  1  slave select.
REQ-007 HREADYIN  in  1  bus ready from the previous data phase.
REQ-008 HADDR  in  32  byte address.
REQ-009 HTRANS  in  2  transfer type: IDLE, BUSY, NONSEQ, SEQ.
REQ-010 HWRITE  in  1  1 = write.
REQ-011 HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
REQ-012 HBURST  in  3  burst type; accepted and ignored.
REQ-013 HWDATA  in  32  write data, valid in the data phase.
REQ-014 HRDATA  out  32  read data.
REQ-015 HREADYOUT  out  1  transfer-done indication.
REQ-016 HRESP  out  2  00 = OKAY, 01 = ERROR.

Function
REQ-017 The block SHALL accept an address phase only when HSEL=1, HREADYIN=1 and HTRANS[1]=1; it SHALL treat NONSEQ and SEQ identically.
REQ-018 IDLE or BUSY transfers, and unselected cycles, SHALL get a zero-wait OKAY response with no memory access.
REQ-019 The block SHALL hold an internal two-port array of MEM_DEPTH x 32 bits, with one write port and one synchronous read port.
REQ-020 Word index SHALL be HADDR[log2(MEM_DEPTH)+1:2].
REQ-021 The error condition SHALL be any one of:
- HADDR bits above log2(MEM_DEPTH)+1 nonzero;
- HSIZE > 2;
- misalignment (half with HADDR[0]=1, or word with HADDR[1:0]≠0).
REQ-022 An error transfer SHALL get a two-cycle response: ERR1 drives HREADYOUT=0, HRESP=01; ERR2 drives HREADYOUT=1, HRESP=01. It SHALL make no memory access.
REQ-023 FSM states SHALL be IDLE, RWAIT, ERR1 and ERR2.
- IDLE→ERR1 on an accepted errored transfer.
- IDLE→RWAIT on an accepted read when RD_WAIT>0.
- RWAIT→IDLE after RD_WAIT cycles.
- ERR1→ERR2→IDLE unconditionally.
REQ-024 Writes SHALL be zero-wait: address, size and byte lanes are registered in the address phase, and the array is written at the end of the data phase using HWDATA.
REQ-025 Byte enables SHALL be decoded from HSIZE and HADDR[1:0] in little-endian order; only the enabled bytes change.
REQ-026 Reads SHALL launch the array read in the address phase.
- With RD_WAIT=0, HRDATA is valid in the next cycle with HREADYOUT=1.
- With RD_WAIT=N, HREADYOUT SHALL be 0 for exactly N data-phase cycles, and HRDATA is valid in the cycle HREADYOUT returns to 1.
REQ-027 HRDATA SHALL return the full 32-bit word regardless of HSIZE.
REQ-028 When FWD_EN=1 and a read's address phase coincides with a write data phase to the same word, HRDATA SHALL return the stored word with the enabled bytes replaced by HWDATA.
REQ-029 When FWD_EN=0, the read in the case of REQ-028 SHALL return the old contents.
REQ-030 A write data phase to word W followed by a later read of W SHALL always return the new data.
REQ-031 HRDATA SHALL be 0 during write data phases, error responses and idle cycles.
REQ-032 Back-to-back accepted transfers SHALL pipeline with no bubble when no wait or error state is active.
REQ-033 An address phase arriving while HREADYOUT=0 cannot be accepted, because HREADYIN=0; the block SHALL ignore it.

Reset
REQ-034 While HRESET=1 at a rising HCLK edge, the FSM SHALL go to IDLE and outputs SHALL become HREADYOUT=1, HRESP=00 and HRDATA=0.
REQ-035 While HRESET=1, any pending write SHALL be dropped and no array write SHALL occur.
REQ-036 Reset asserted mid-RWAIT or mid-ERR1 SHALL abort the response, and the next cycle SHALL be IDLE.
REQ-037 Array contents SHALL NOT be cleared by reset and are undefined after power-up.

Verification
REQ-038 The bench SHALL cover each of these directed scenarios:
- Word write 0xDEADBEEF to 0x10, then word read 0x10 with RD_WAIT=0 → HRDATA=0xDEADBEEF the next cycle; HREADYOUT never low.
- Byte write 0xAA to 0x11 over stored 0x11223344, then read 0x10 → 0x1122AA44.
- RD_WAIT=2, read 0x20 → HREADYOUT low for exactly 2 cycles, then high with the stored data and HRESP=00.
- Read of 0x14 issued in the data phase of a word write 0x55667788 to 0x14, FWD_EN=1 → 0x55667788.
- The same case with FWD_EN=0 → the old value.
- Each error case → HREADYOUT 0 then 1, HRESP=01 on both cycles, memory unchanged:
  - word access to 0x02;
  - access at address 4*MEM_DEPTH;
  - HSIZE=3.
- HRESET pulsed during RWAIT → HREADYOUT=1, HRESP=00, HRDATA=0 the next cycle; a subsequent read completes normally.
